// File: rtl/q2_mem_arb.sv
// q2_mem_arb: two-requester memory cycle arbiter (CPU and front panel).
//
// A granted cycle walks IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
// - SETUP: address and data are driven, with no strobe.
// - STROBE: the read or write strobe is held for STROBE_CYC cycles.
// - HOLD: strobes are low and the granted requester sees a one-cycle ack.
// Every output comes straight from a flop.
//
// Parameters:
//   STROBE_CYC  memory strobe width in clk cycles (1..15)
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   run                            CPU running flag (panel is held off while high)
//   cpu_rd/cpu_wr/cpu_addr/cpu_wdata -> cpu_ack, cpu_rdata
//   pnl_req/pnl_we/pnl_addr/pnl_wdata -> pnl_ack, pnl_rdata
//   mem_addr/mem_wdata/mem_oe/mem_rd/mem_wr, mem_rdata
//   busy                           high whenever the FSM is not idle
//
// Build option:
//   Q2_ARB_PANEL_PRIO_EN  when defined, the panel wins every tie.
//                         Otherwise ties go round-robin.

module q2_mem_arb #(
    parameter int STROBE_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [11:0] cpu_addr,
    input  logic [11:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [11:0] cpu_rdata,
    input  logic        pnl_req,
    input  logic        pnl_we,
    input  logic [11:0] pnl_addr,
    input  logic [11:0] pnl_wdata,
    output logic        pnl_ack,
    output logic [11:0] pnl_rdata,
    output logic [11:0] mem_addr,
    output logic [11:0] mem_wdata,
    output logic        mem_oe,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [11:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant_pnl_q, grant_pnl_d;
    logic        dir_wr_q, dir_wr_d;
    logic [11:0] mem_addr_q, mem_addr_d;
    logic [11:0] mem_wdata_q, mem_wdata_d;
    logic        mem_oe_q, mem_oe_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        pnl_ack_q, pnl_ack_d;
    logic [11:0] cpu_rdata_q, cpu_rdata_d;
    logic [11:0] pnl_rdata_q, pnl_rdata_d;
    logic        busy_q, busy_d;

    logic        cpu_pend;
    logic        pnl_pend;
    logic        pick_pnl;
    logic        sel_wr;
    logic [11:0] sel_addr;
    logic [11:0] sel_wdata;

    // The panel may only take the bus while the CPU is halted. While run is
    // high, its request simply stays pending. It is never dropped.
    assign cpu_pend = cpu_rd | cpu_wr;
    assign pnl_pend = pnl_req & ~run;

`ifdef Q2_ARB_PANEL_PRIO_EN
    assign pick_pnl = pnl_pend;
`else
    // last_pnl_q is 1 when the panel held the most recent grant.
    // Reset leaves it at 1, so the CPU wins the first tie.
    logic last_pnl_q, last_pnl_d;

    assign pick_pnl = pnl_pend & (~cpu_pend | ~last_pnl_q);

    always_comb begin
        last_pnl_d = last_pnl_q;
        if (state_q == IDLE && (cpu_pend || pnl_pend)) begin
            last_pnl_d = pick_pnl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pnl_q <= 1'b1;
        end else begin
            last_pnl_q <= last_pnl_d;
        end
    end
`endif

    // A CPU cycle with both rd and wr high is treated as a write.
    assign sel_wr    = pick_pnl ? pnl_we    : cpu_wr;
    assign sel_addr  = pick_pnl ? pnl_addr  : cpu_addr;
    assign sel_wdata = pick_pnl ? pnl_wdata : cpu_wdata;

    // Next-state and registered-output logic.
    // The request, address, data and direction are sampled only in IDLE.
    // After that, each stage works only from the latched copies.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_pnl_d = grant_pnl_q;
        dir_wr_d    = dir_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_oe_d    = mem_oe_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        cpu_ack_d   = 1'b0;
        pnl_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        pnl_rdata_d = pnl_rdata_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (cpu_pend || pnl_pend) begin
                    state_d     = SETUP;
                    grant_pnl_d = pick_pnl;
                    dir_wr_d    = sel_wr;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_oe_d    = sel_wr;
                    busy_d      = 1'b1;
                end
            end
            SETUP: begin
                state_d  = STROBE;
                cnt_d    = CNT_LOAD;
                mem_rd_d = ~dir_wr_q;
                mem_wr_d = dir_wr_q;
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d   = HOLD;
                    mem_rd_d  = 1'b0;
                    mem_wr_d  = 1'b0;
                    cpu_ack_d = ~grant_pnl_q;
                    pnl_ack_d = grant_pnl_q;
                    // Read data is captured on the edge that ends the strobe.
                    // Only the requester that owns the cycle gets the new data.
                    if (!dir_wr_q) begin
                        if (grant_pnl_q) begin
                            pnl_rdata_d = mem_rdata;
                        end else begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                state_d  = IDLE;
                mem_oe_d = 1'b0;
                busy_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and output flops. Reset cancels any cycle in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            grant_pnl_q <= 1'b0;
            dir_wr_q    <= 1'b0;
            mem_addr_q  <= 12'd0;
            mem_wdata_q <= 12'd0;
            mem_oe_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            pnl_ack_q   <= 1'b0;
            cpu_rdata_q <= 12'd0;
            pnl_rdata_q <= 12'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_pnl_q <= grant_pnl_d;
            dir_wr_q    <= dir_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_oe_q    <= mem_oe_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            cpu_ack_q   <= cpu_ack_d;
            pnl_ack_q   <= pnl_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            pnl_rdata_q <= pnl_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_oe    = mem_oe_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign cpu_ack   = cpu_ack_q;
    assign pnl_ack   = pnl_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign pnl_rdata = pnl_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_q2_mem_arb.sv
// tb_q2_mem_arb: directed self-checking bench for q2_mem_arb.
//
// Instances:
//   u_dut1  STROBE_CYC = 1
//   u_dut3  STROBE_CYC = 3
// Both instances share the stimulus and the reset. Each test starts from a
// fresh reset and checks only the instance it is written for.

module tb_q2_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        cpu_rd, cpu_wr;
    logic [11:0] cpu_addr, cpu_wdata;
    logic        pnl_req, pnl_we;
    logic [11:0] pnl_addr, pnl_wdata;
    logic [11:0] mem_rdata;

    logic        cpu_ack_1, pnl_ack_1, mem_oe_1, mem_rd_1, mem_wr_1, busy_1;
    logic [11:0] cpu_rdata_1, pnl_rdata_1, mem_addr_1, mem_wdata_1;
    logic        cpu_ack_3, pnl_ack_3, mem_oe_3, mem_rd_3, mem_wr_3, busy_3;
    logic [11:0] cpu_rdata_3, pnl_rdata_3, mem_addr_3, mem_wdata_3;

    int err_count   = 0;
    int check_count = 0;

    always #5 clk = ~clk;

    q2_mem_arb #(.STROBE_CYC(1)) u_dut1 (
        .clk(clk), .rst(rst), .run(run),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack_1), .cpu_rdata(cpu_rdata_1),
        .pnl_req(pnl_req), .pnl_we(pnl_we), .pnl_addr(pnl_addr), .pnl_wdata(pnl_wdata),
        .pnl_ack(pnl_ack_1), .pnl_rdata(pnl_rdata_1),
        .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_oe(mem_oe_1),
        .mem_rd(mem_rd_1), .mem_wr(mem_wr_1), .mem_rdata(mem_rdata), .busy(busy_1)
    );

    q2_mem_arb #(.STROBE_CYC(3)) u_dut3 (
        .clk(clk), .rst(rst), .run(run),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack_3), .cpu_rdata(cpu_rdata_3),
        .pnl_req(pnl_req), .pnl_we(pnl_we), .pnl_addr(pnl_addr), .pnl_wdata(pnl_wdata),
        .pnl_ack(pnl_ack_3), .pnl_rdata(pnl_rdata_3),
        .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_oe(mem_oe_3),
        .mem_rd(mem_rd_3), .mem_wr(mem_wr_3), .mem_rdata(mem_rdata), .busy(busy_3)
    );

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: observed=%0o expected=%0o", tag, observed, expected);
        end
    endtask

    // Drives every requester input in one call.
    task automatic applyStimulus(input logic r, input logic c_rd, input logic c_wr,
                                 input logic [11:0] c_addr, input logic [11:0] c_wdata,
                                 input logic p_req, input logic p_we,
                                 input logic [11:0] p_addr, input logic [11:0] p_wdata);
        run       = r;
        cpu_rd    = c_rd;
        cpu_wr    = c_wr;
        cpu_addr  = c_addr;
        cpu_wdata = c_wdata;
        pnl_req   = p_req;
        pnl_we    = p_we;
        pnl_addr  = p_addr;
        pnl_wdata = p_wdata;
    endtask

    // Advances to 1 ns after the next rising edge.
    // Inputs are driven here, and registered outputs are sampled here.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_rdata = 12'd0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Raises both requests together from idle and waits for one grant.
    // Both requests are dropped on the edge that samples the ack.
    // The task then waits out one idle cycle.
    task automatic serveTie(output logic pnl_won, output logic done);
        applyStimulus(0, 1, 0, 12'o0010, 0, 1, 0, 12'o0020, 0);
        done    = 1'b0;
        pnl_won = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick;
            if (cpu_ack_1 || pnl_ack_1) begin
                done    = 1'b1;
                pnl_won = pnl_ack_1;
                checkOutput("tie_single_ack", {31'd0, cpu_ack_1 & pnl_ack_1}, 0);
            end
        end
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] exp_oe, exp_wr, exp_ack;
        logic [2:0] exp_tie;
        logic [3:0] exp_order;
        logic [3:0] order;
        int         grants;
        int         wr_cycles;
        logic       won, done;
        logic       prev_ca, prev_pa, cpu_low, pnl_low, ca, pa;

        // Reset state.
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_rdata = 12'd0;
        tick;
        checkOutput("rst_busy",    {31'd0, busy_1 | busy_3}, 0);
        checkOutput("rst_strobes", {29'd0, mem_rd_1, mem_wr_1, mem_oe_1}, 0);
        checkOutput("rst_acks",    {30'd0, cpu_ack_1, pnl_ack_1}, 0);
        checkOutput("rst_addr",    {20'd0, mem_addr_1}, 0);
        checkOutput("rst_wdata",   {20'd0, mem_wdata_3}, 0);
        checkOutput("rst_rdata",   {8'd0, cpu_rdata_1, pnl_rdata_1}, 0);

        // CPU read, STROBE_CYC = 1.
        resetDut;
        mem_rdata = 12'o7070;
        applyStimulus(0, 1, 0, 12'o1234, 0, 0, 0, 0, 0);
        tick;
        checkOutput("rd_setup_busy", {31'd0, busy_1}, 1);
        checkOutput("rd_setup_addr", {20'd0, mem_addr_1}, 12'o1234);
        checkOutput("rd_setup_strb", {29'd0, mem_oe_1, mem_rd_1, mem_wr_1}, 0);
        tick;
        checkOutput("rd_strobe_rd",  {31'd0, mem_rd_1}, 1);
        checkOutput("rd_strobe_ack", {31'd0, cpu_ack_1}, 0);
        tick;
        checkOutput("rd_hold_rd",    {31'd0, mem_rd_1}, 0);
        checkOutput("rd_hold_ack",   {31'd0, cpu_ack_1}, 1);
        checkOutput("rd_hold_rdata", {20'd0, cpu_rdata_1}, 12'o7070);
        checkOutput("rd_hold_addr",  {20'd0, mem_addr_1}, 12'o1234);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd_idle_ack",   {31'd0, cpu_ack_1}, 0);
        checkOutput("rd_idle_busy",  {31'd0, busy_1}, 0);
        checkOutput("rd_pnl_rdata",  {20'd0, pnl_rdata_1}, 0);

        // Panel deposit, STROBE_CYC = 3.
        // Cycles 1..6 after the request: SETUP, STROBE x3, HOLD, IDLE.
        resetDut;
        mem_rdata = 12'o4321;
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 12'o0100, 12'o5555);
        exp_oe    = 6'b011111;
        exp_wr    = 6'b001110;
        exp_ack   = 6'b010000;
        wr_cycles = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            checkOutput($sformatf("dep_oe_c%0d", k + 1),   {31'd0, mem_oe_3},  {31'd0, exp_oe[k]});
            checkOutput($sformatf("dep_wr_c%0d", k + 1),   {31'd0, mem_wr_3},  {31'd0, exp_wr[k]});
            checkOutput($sformatf("dep_ack_c%0d", k + 1),  {31'd0, pnl_ack_3}, {31'd0, exp_ack[k]});
            checkOutput($sformatf("dep_busy_c%0d", k + 1), {31'd0, busy_3},    {31'd0, exp_oe[k]});
            if (mem_wr_3) wr_cycles++;
            if (k == 1) begin
                checkOutput("dep_addr",  {20'd0, mem_addr_3},  12'o0100);
                checkOutput("dep_wdata", {20'd0, mem_wdata_3}, 12'o5555);
                checkOutput("dep_no_rd", {31'd0, mem_rd_3}, 0);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("dep_wr_cycles", wr_cycles, 3);
        checkOutput("dep_pnl_rdata", {20'd0, pnl_rdata_3}, 0);
        checkOutput("dep_cpu_rdata", {20'd0, cpu_rdata_3}, 0);

        // run = 1: the CPU is served and the panel waits.
        // The panel is served after run falls, and a run rise mid-cycle
        // does not abort it.
        resetDut;
        mem_rdata = 12'o1111;
        applyStimulus(1, 1, 0, 12'o0300, 0, 1, 0, 12'o0200, 0);
        tick;
        checkOutput("run_cpu_addr", {20'd0, mem_addr_1}, 12'o0300);
        tick;
        tick;
        checkOutput("run_cpu_ack",   {30'd0, cpu_ack_1, pnl_ack_1}, 2'b10);
        checkOutput("run_cpu_rdata", {20'd0, cpu_rdata_1}, 12'o1111);
        tick;
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 12'o0200, 0);
        checkOutput("run_idle0", {31'd0, busy_1}, 0);
        tick;
        checkOutput("run_hold1", {31'd0, busy_1}, 0);
        tick;
        checkOutput("run_hold2", {31'd0, busy_1}, 0);
        mem_rdata = 12'o2222;
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 12'o0200, 0);
        tick;
        checkOutput("run_pnl_busy", {31'd0, busy_1}, 1);
        checkOutput("run_pnl_addr", {20'd0, mem_addr_1}, 12'o0200);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 12'o0200, 0);
        tick;
        tick;
        checkOutput("run_pnl_ack",   {30'd0, cpu_ack_1, pnl_ack_1}, 2'b01);
        checkOutput("run_pnl_rdata", {20'd0, pnl_rdata_1}, 12'o2222);
        checkOutput("run_cpu_keep",  {20'd0, cpu_rdata_1}, 12'o1111);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // cpu_rd and cpu_wr together: the cycle is a write.
        resetDut;
        mem_rdata = 12'o3333;
        applyStimulus(0, 1, 1, 12'o0040, 12'o1357, 0, 0, 0, 0);
        tick;
        checkOutput("rw_setup_oe", {31'd0, mem_oe_1}, 1);
        tick;
        checkOutput("rw_strobe", {30'd0, mem_rd_1, mem_wr_1}, 2'b01);
        checkOutput("rw_wdata",  {20'd0, mem_wdata_1}, 12'o1357);
        tick;
        checkOutput("rw_ack",   {31'd0, cpu_ack_1}, 1);
        checkOutput("rw_rdata", {20'd0, cpu_rdata_1}, 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Genuine ties from idle.
`ifdef Q2_ARB_PANEL_PRIO_EN
        exp_tie = 3'b111;
`else
        exp_tie = 3'b010;
`endif
        resetDut;
        for (int r = 0; r < 3; r++) begin
            serveTie(won, done);
            checkOutput($sformatf("tie_done_%0d", r), {31'd0, done}, 1);
            checkOutput($sformatf("tie_winner_%0d", r), {31'd0, won}, {31'd0, exp_tie[r]});
        end

        // Requests held continuously.
        // Each requester drops for one cycle after its own ack.
        // Grant order is recorded as bits: 0 = CPU, 1 = panel.
`ifdef Q2_ARB_PANEL_PRIO_EN
        exp_order = 4'b0101;
`else
        exp_order = 4'b1010;
`endif
        resetDut;
        applyStimulus(0, 1, 0, 12'o0010, 0, 1, 0, 12'o0020, 0);
        grants  = 0;
        order   = 4'd0;
        prev_ca = 1'b0;
        prev_pa = 1'b0;
        cpu_low = 1'b0;
        pnl_low = 1'b0;
        for (int i = 0; i < 60 && grants < 4; i++) begin
            tick;
            ca = cpu_ack_1;
            pa = pnl_ack_1;
            if (prev_ca) begin
                cpu_rd  = 1'b0;
                cpu_low = 1'b1;
            end else if (cpu_low) begin
                cpu_rd  = 1'b1;
                cpu_low = 1'b0;
            end
            if (prev_pa) begin
                pnl_req = 1'b0;
                pnl_low = 1'b1;
            end else if (pnl_low) begin
                pnl_req = 1'b1;
                pnl_low = 1'b0;
            end
            if ((ca || pa) && grants < 4) begin
                order[grants] = pa;
                grants++;
            end
            prev_ca = ca;
            prev_pa = pa;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("hold_grants", grants, 4);
        for (int g = 0; g < 4; g++) begin
            checkOutput($sformatf("hold_order_%0d", g), {31'd0, order[g]}, {31'd0, exp_order[g]});
        end

        // Reset during the strobe of a CPU write, STROBE_CYC = 3.
        resetDut;
        applyStimulus(0, 0, 1, 12'o0500, 12'o0707, 0, 0, 0, 0);
        tick;
        tick;
        checkOutput("abort_pre_wr", {31'd0, mem_wr_3}, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_wr_drop", {29'd0, mem_wr_3, mem_oe_3, busy_3}, 0);
        tick;
        checkOutput("abort_no_ack", {31'd0, cpu_ack_3}, 0);
        tick;
        checkOutput("abort_no_ack2", {31'd0, cpu_ack_3}, 0);
        rst = 1'b0;
        wr_cycles = 0;
        for (int k = 1; k <= 5; k++) begin
            tick;
            if (mem_wr_3) wr_cycles++;
            checkOutput($sformatf("regrant_ack_c%0d", k), {31'd0, cpu_ack_3}, (k == 5) ? 1 : 0);
        end
        checkOutput("regrant_wr_cycles", wr_cycles, 3);
        checkOutput("regrant_addr", {20'd0, mem_addr_3}, 12'o0500);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("regrant_idle", {30'd0, cpu_ack_3, busy_3}, 0);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
